// File: rtl/i2c_slave.sv
// I2C target: 2-flop synced SCL/SDA, registered edge/START/STOP detect (3 clk), FSM drives SDA 1 clk later.
// Never stretches SCL; tx_data must be stable from the tx_req pulse until the next SCL fall.
module i2c_slave #(
  parameter logic [6:0] I2C_ADDR = 7'h77
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    RX       = 4'd3,
    RX_ACK   = 4'd4,
    TX       = 4'd5,
    TX_ACK   = 4'd6
  } state_t;

  state_t     st;
  logic [2:0] scl_sh, sda_sh;
  logic       scl_rise, scl_fall, start_det, stop_det, sda_smp;
  logic [7:0] shreg;
  logic [2:0] cnt;
  logic       done;
  logic       sda_low;

  assign sda   = sda_low ? 1'b0 : 1'bz;
  assign state = st;

  // Bus idles high, so the synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sh    <= 3'b111;
      sda_sh    <= 3'b111;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_smp   <= 1'b1;
    end else begin
      scl_sh    <= {scl_sh[1:0], sclk};
      sda_sh    <= {sda_sh[1:0], sda};
      scl_rise  <= scl_sh[1] & ~scl_sh[2];
      scl_fall  <= ~scl_sh[1] & scl_sh[2];
      start_det <= ~sda_sh[1] & sda_sh[2] & scl_sh[1];
      stop_det  <= sda_sh[1] & ~sda_sh[2] & scl_sh[1];
      sda_smp   <= sda_sh[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      shreg    <= 8'h00;
      cnt      <= 3'd0;
      done     <= 1'b0;
      sda_low  <= 1'b0;
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      if (start_det) begin
        st      <= ADDR;
        cnt     <= 3'd0;
        done    <= 1'b0;
        sda_low <= 1'b0;
      end else if (stop_det) begin
        st      <= IDLE;
        cnt     <= 3'd0;
        done    <= 1'b0;
        sda_low <= 1'b0;
      end else begin
        case (st)
          IDLE: sda_low <= 1'b0;
          ADDR: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_smp};
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) done <= 1'b1;
            end else if (scl_fall && done) begin
              done <= 1'b0;
              if (shreg[7:1] == I2C_ADDR) begin
                sda_low <= 1'b1;
                tx_req  <= shreg[0];
                st      <= ADDR_ACK;
              end else begin
                st <= IDLE;
              end
            end
          end
          // shreg still holds the address byte here, so bit 0 is R/W.
          ADDR_ACK: begin
            if (scl_fall) begin
              cnt <= 3'd0;
              if (shreg[0]) begin
                shreg   <= tx_data;
                sda_low <= ~tx_data[7];
                st      <= TX;
              end else begin
                sda_low <= 1'b0;
                st      <= RX;
              end
            end
          end
          RX: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_smp};
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) done <= 1'b1;
            end else if (scl_fall && done) begin
              done     <= 1'b0;
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              sda_low  <= 1'b1;
              st       <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_low <= 1'b0;
              cnt     <= 3'd0;
              st      <= RX;
            end
          end
          TX: begin
            if (scl_fall) begin
              if (cnt == 3'd7) begin
                sda_low <= 1'b0;
                cnt     <= 3'd0;
                st      <= TX_ACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_low <= ~shreg[6];
                cnt     <= cnt + 3'd1;
              end
            end
          end
          // done marks a master ACK seen on the rise; the following fall reloads.
          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_smp) begin
                tx_req <= 1'b1;
                done   <= 1'b1;
              end else begin
                st <= IDLE;
              end
            end else if (scl_fall && done) begin
              done    <= 1'b0;
              shreg   <= tx_data;
              sda_low <= ~tx_data[7];
              cnt     <= 3'd0;
              st      <= TX;
            end
          end
          default: begin
            st      <= IDLE;
            sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (responder) for the bus driven by the team's I2C master. It watches `sclk`/`sda` with the system clock and detects START/STOP. It answers a 7-bit address, then either accepts write bytes or returns read bytes through a simple byte-wide local interface. `sda` is open-drain: the block only ever pulls it low or releases it.

## Interface
- `I2C_ADDR`, default 7'h77: 7-bit target address. Address byte 8'hee or 8'hef matches.
- `clk`  input  1  system clock; must run at ≥ 16× the SCL frequency.
- `rst`  input  1  reset, asynchronous, active-low.
- `sclk`  input  1  I2C serial clock from the master.
- `sda`  inout  1  I2C data; driven 1'b0 or 1'bz only.
- `tx_data`  input  8  byte returned on a master read; sampled when loaded.
- `tx_req`  output  1  one-clk pulse: a read byte is about to be loaded from `tx_data`.
- `rx_data`  output  8  last byte written by the master.
- `rx_valid`  output  1  one-clk pulse: `rx_data` updated.
- `state`  output  4  current FSM state, for debug.

## Operation
- Inputs: `sclk` and `sda` each pass through a 2-flop synchronizer. A third flop provides edge detection on the synchronized values (`scl_rise`, `scl_fall`, `sda_rise`, `sda_fall`).
- START = `sda_fall` while synced SCL is high. STOP = `sda_rise` while synced SCL is high. Both are detected in every state and take priority over the data edges in the same clk.
- On START, including a repeated START: go to ADDR, clear the bit counter, release `sda`.
- On STOP: go to IDLE, release `sda`.
- Bytes are MSB first. Data is sampled on `scl_rise`. `sda` changes only on `scl_fall`.
- States and encoding:
  - IDLE=0: `sda` released; waits for START.
  - ADDR=1: shifts in 8 bits.
    - After the 8th rise, compare bits[7:1] with `I2C_ADDR`.
    - Match: on the next fall, pull `sda` low and go to ADDR_ACK. If R/W=1, pulse `tx_req` in this same clk.
    - Mismatch: go to IDLE without driving.
  - ADDR_ACK=2: on the fall that ends the ACK bit:
    - R/W=0: release `sda` and go to RX.
    - R/W=1: load `tx_data` into the shift register, drive bit7 (low if 0, else release), and go to TX.
  - RX=3: after 8 rises, on the next fall:
    - `rx_data` ← shift register; pulse `rx_valid` for 1 clk.
    - Pull `sda` low (ACK) and go to RX_ACK.
    - Every written byte is ACKed.
  - RX_ACK=4: on the next fall, release `sda`, clear the counter, and go to RX.
  - TX=5: on each fall, present the next bit. After the fall that ends bit0, release `sda` and go to TX_ACK.
  - TX_ACK=6: sample `sda` on the rise.
    - 0 (ACK): pulse `tx_req`. On the next fall, load `tx_data`, drive bit7, and go to TX.
    - 1 (NACK): go to IDLE with `sda` released.
- Bit counter: 3 bits plus a byte-done flag. It wraps 7→0 at each byte boundary.
- Undefined codes 7–15: treated as IDLE on the next clk.

## Timing
- Reset values: `sda` released, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `state`=0 (IDLE), counter=0, shift register=0.
- Reset mid-transaction releases `sda` asynchronously, with no clk required.
- Pin-to-detect latency is 3 clk. `sda` is driven 1 clk after `scl_fall` is detected, i.e. 4 clk after the pin edge.
- `tx_data` must be stable from the `tx_req` pulse until the next `scl_fall`, which is at least ~8 clk at 16× oversampling.
- `rx_valid` rises in the same clk that `rx_data` changes. `rx_data` holds until the next byte.
- The block never stretches SCL. The master must not change `sda` while SCL is high, except for START/STOP.

## Test plan
- Write: START, 8'hee (ACK), 8'hA5, STOP.
  - `sda` is low in both 9th bits.
  - `rx_data`=8'hA5 with exactly one `rx_valid` pulse.
  - `state` ends at 0.
- Address mismatch: START, 8'h24, then 8'h11.
  - `sda` is never driven low.
  - No `rx_valid`.
  - `state` returns to 0 after the 8th bit.
- Read, 2 bytes: START, 8'hef, `tx_data`=8'h3C; master ACKs; `tx_data` changed to 8'hC3; master NACKs; STOP.
  - Bus carries 3C then C3.
  - Two `tx_req` pulses.
  - `sda` released after the NACK.
- Repeated START: write 8'hee + 8'h5A, then Sr + 8'hef with `tx_data`=8'h81.
  - `rx_data`=8'h5A.
  - Read byte is 8'h81 with no intervening STOP.
- STOP after 4 bits of an RX byte.
  - `state`→0 within 4 clk.
  - No `rx_valid`.
  - The next write of 8'h0F is received correctly.
- `rst` low during TX while `sda` is driven low.
  - `sda`=z immediately.
  - All outputs at their reset values.
  - The transaction following release completes normally.
